pc_unit: RTL and testbench

//  Parametrised program-counter unit for the RV32I core. Extends the plain PC register with

---
 rtl/pc_unit.sv | 155 +++++++++++++++
 tb/tb_pc_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit: program-counter unit for the RV32I core.
// Holds the fetch PC and selects the next PC from trap entry, stall hold,
// trap return (mepc), branch/jump redirect, return-address-stack prediction
// or sequential increment. Misaligned redirects are turned into traps and the
// offending target is latched in fault_addr.
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_1000,
    parameter logic [XLEN-1:0]  TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned      IALIGN    = 4,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          stall,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          trap,
    input  logic                          mret,
    input  logic                          ras_push,
    input  logic                          ras_pop,
    output logic [XLEN-1:0]               pc,
    output logic [XLEN-1:0]               pc_plus4,
    output logic [XLEN-1:0]               mepc,
    output logic                          misalign_fault,
    output logic [XLEN-1:0]               fault_addr,
    output logic [$clog2(RAS_DEPTH):0]    ras_count
);

    // Number of low target bits that must be zero (IALIGN is 2 or 4).
    localparam int unsigned ALB = $clog2(IALIGN);
    // RAS pointer and occupancy widths.
    localparam int unsigned PW  = $clog2(RAS_DEPTH);
    localparam int unsigned CW  = $clog2(RAS_DEPTH) + 1;

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] fault_addr_r;
    logic            misalign_fault_r;
    logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0]   ras_top_r;
    logic [CW-1:0]   ras_count_r;

    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] pc_next_s;
    logic            misaligned_s;
    logic            take_trap_s;
    logic            pop_ok_s;
    logic            ras_update_s;
    logic [PW-1:0]   top_inc_s;
    logic [PW-1:0]   top_dec_s;

    assign pc_plus4_s = pc_r + XLEN'(4);

    // Event decode, RAS pointer arithmetic and next-pc priority selection.
    always_comb begin
        misaligned_s = redirect_valid && (redirect_pc[ALB-1:0] != {ALB{1'b0}});
        take_trap_s  = trap || misaligned_s;
        pop_ok_s     = ras_pop && (ras_count_r != {CW{1'b0}});
        ras_update_s = !take_trap_s && !stall;

        // Circular wrap written explicitly so non-power-of-two depths work.
        if (ras_top_r == PW'(RAS_DEPTH - 1)) begin
            top_inc_s = {PW{1'b0}};
        end else begin
            top_inc_s = ras_top_r + PW'(1);
        end
        if (ras_top_r == {PW{1'b0}}) begin
            top_dec_s = PW'(RAS_DEPTH - 1);
        end else begin
            top_dec_s = ras_top_r - PW'(1);
        end

        if (take_trap_s) begin
            pc_next_s = TRAP_VEC;
        end else if (stall) begin
            pc_next_s = pc_r;
        end else if (mret) begin
            pc_next_s = {mepc_r[XLEN-1:ALB], {ALB{1'b0}}};
        end else if (redirect_valid) begin
            pc_next_s = redirect_pc;
        end else if (pop_ok_s) begin
            pc_next_s = ras_mem_r[ras_top_r];
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // PC, trap return address and misalignment reporting registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r             <= RESET_PC;
            mepc_r           <= {XLEN{1'b0}};
            fault_addr_r     <= {XLEN{1'b0}};
            misalign_fault_r <= 1'b0;
        end else begin
            pc_r             <= pc_next_s;
            misalign_fault_r <= misaligned_s;
            if (take_trap_s) begin
                mepc_r <= pc_r;
            end else begin
                mepc_r <= mepc_r;
            end
            if (misaligned_s) begin
                fault_addr_r <= redirect_pc;
            end else begin
                fault_addr_r <= fault_addr_r;
            end
        end
    end

    // Return-address stack: circular buffer, frozen on trap cycles and stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= {XLEN{1'b0}};
            end
            ras_top_r   <= {PW{1'b0}};
            ras_count_r <= {CW{1'b0}};
        end else if (ras_update_s) begin
            if (ras_push && pop_ok_s) begin
                // Call immediately after a predicted return: replace the top.
                ras_mem_r[ras_top_r] <= pc_plus4_s;
            end else if (ras_push) begin
                // When full the write lands on the oldest entry.
                ras_mem_r[top_inc_s] <= pc_plus4_s;
                ras_top_r            <= top_inc_s;
                if (ras_count_r != CW'(RAS_DEPTH)) begin
                    ras_count_r <= ras_count_r + CW'(1);
                end else begin
                    ras_count_r <= ras_count_r;
                end
            end else if (pop_ok_s) begin
                ras_top_r   <= top_dec_s;
                ras_count_r <= ras_count_r - CW'(1);
            end else begin
                ras_top_r   <= ras_top_r;
                ras_count_r <= ras_count_r;
            end
        end else begin
            ras_top_r   <= ras_top_r;
            ras_count_r <= ras_count_r;
        end
    end

    assign pc             = pc_r;
    assign pc_plus4       = pc_plus4_s;
    assign mepc           = mepc_r;
    assign fault_addr     = fault_addr_r;
    assign misalign_fault = misalign_fault_r;
    assign ras_count      = ras_count_r;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit: directed self-checking bench for pc_unit.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic        mret;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] mepc;
    logic        misalign_fault;
    logic [31:0] fault_addr;
    logic [2:0]  ras_count;

    int total;
    int bad;

    pc_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap           (trap),
        .mret           (mret),
        .ras_push       (ras_push),
        .ras_pop        (ras_pop),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .mepc           (mepc),
        .misalign_fault (misalign_fault),
        .fault_addr     (fault_addr),
        .ras_count      (ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        trap = 1'b0; mret = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        reset_n = 1'b0;

        // 1: reset values and free-running increment
        #12;
        check("rst_pc",    pc, 32'h0000_1000);
        check("rst_mepc",  mepc, 32'h0);
        check("rst_fault", {31'h0, misalign_fault}, 32'h0);
        check("rst_faddr", fault_addr, 32'h0);
        check("rst_cnt",   {29'h0, ras_count}, 32'h0);
        check("rst_plus4", pc_plus4, 32'h0000_1004);
        @(negedge clk);
        reset_n = 1'b1;
        tick(); check("free1", pc, 32'h0000_1004);
        tick(); check("free2", pc, 32'h0000_1008);
        tick(); check("free3", pc, 32'h0000_100C);
        check("free_cnt", {29'h0, ras_count}, 32'h0);

        // 2: stalled redirect holds, then applies
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; stall = 1'b1;
        tick(); check("stall_hold", pc, 32'h0000_100C);
        stall = 1'b0;
        tick(); check("redir", pc, 32'h0000_2000);

        // 3: misaligned redirect traps, then mret returns
        redirect_pc = 32'h0000_2002;
        tick();
        check("mis_pc",    pc, 32'h0000_0100);
        check("mis_mepc",  mepc, 32'h0000_2000);
        check("mis_faddr", fault_addr, 32'h0000_2002);
        check("mis_pulse", {31'h0, misalign_fault}, 32'h1);
        idle();
        tick();
        check("mis_pulse_end", {31'h0, misalign_fault}, 32'h0);
        check("mis_next", pc, 32'h0000_0104);
        check("faddr_hold", fault_addr, 32'h0000_2002);
        mret = 1'b1;
        tick(); check("mret_pc", pc, 32'h0000_2000);
        idle();

        // 4: five calls into a 4-deep RAS, then five returns
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
        tick(); check("call_base", pc, 32'h0000_3000);
        ras_push = 1'b1;
        redirect_pc = 32'h0000_3100; tick(); check("call1_cnt", {29'h0, ras_count}, 32'h1);
        redirect_pc = 32'h0000_3200; tick(); check("call2_pc", pc, 32'h0000_3200);
        redirect_pc = 32'h0000_3300; tick(); check("call3_cnt", {29'h0, ras_count}, 32'h3);
        redirect_pc = 32'h0000_3400; tick(); check("call4_cnt", {29'h0, ras_count}, 32'h4);
        redirect_valid = 1'b0;
        tick();
        check("call5_pc",  pc, 32'h0000_3404);
        check("call5_cnt", {29'h0, ras_count}, 32'h4);
        idle(); ras_pop = 1'b1;
        tick(); check("ret1", pc, 32'h0000_3404);
        tick(); check("ret2", pc, 32'h0000_3304);
        tick(); check("ret3", pc, 32'h0000_3204);
        tick(); check("ret4", pc, 32'h0000_3104);
        check("ret4_cnt", {29'h0, ras_count}, 32'h0);
        tick(); check("ret5_empty", pc, 32'h0000_3108);
        check("ret5_cnt", {29'h0, ras_count}, 32'h0);

        // 5: trap beats stall and redirect; RAS frozen and preserved
        idle(); ras_push = 1'b1;
        tick(); check("push1_pc", pc, 32'h0000_310C);
        check("push1_cnt", {29'h0, ras_count}, 32'h1);
        trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_5000; stall = 1'b1;
        tick();
        check("trap_pc",   pc, 32'h0000_0100);
        check("trap_mepc", mepc, 32'h0000_310C);
        check("trap_cnt",  {29'h0, ras_count}, 32'h1);
        check("trap_nofault", {31'h0, misalign_fault}, 32'h0);
        idle(); mret = 1'b1;
        tick(); check("mret2_pc", pc, 32'h0000_310C);
        idle(); ras_push = 1'b1; ras_pop = 1'b1;
        tick();
        check("pushpop_pc",  pc, 32'h0000_310C);
        check("pushpop_cnt", {29'h0, ras_count}, 32'h1);
        idle(); ras_pop = 1'b1;
        tick();
        check("pop_replaced", pc, 32'h0000_3110);
        check("pop_cnt", {29'h0, ras_count}, 32'h0);

        // 6: address wrap, then asynchronous reset during a stall
        idle(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); check("top_pc", pc, 32'hFFFF_FFFC);
        check("top_plus4", pc_plus4, 32'h0000_0000);
        idle();
        tick(); check("wrap_pc", pc, 32'h0000_0000);
        check("wrap_nofault", {31'h0, misalign_fault}, 32'h0);
        stall = 1'b1;
        tick(); check("stall_zero", pc, 32'h0000_0000);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_pc",    pc, 32'h0000_1000);
        check("async_mepc",  mepc, 32'h0);
        check("async_faddr", fault_addr, 32'h0);
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        tick(); check("after_rst", pc, 32'h0000_1004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
